mem_responder: RTL and testbench

//  Memory-side responder for the control unit's MOV/MOC memory handshake.
//  The CPU drives MOV/RW with the MAR address and MDR data; this block performs the access against an internal word array.
//  It acknowledges with MOC after a programmable number of wait states, then returns read data for MDR loading.
//  It sits between the datapath MAR/MDR registers and the behavioural RAM.

---
 rtl/mem_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the control unit's MOV/MOC four-phase handshake.
// The CPU raises mov with the MAR address and MDR data. This block captures
// the request and waits a programmable number of wait states. It then performs
// the access against an internal big-endian word array and raises moc. moc
// stays high until the CPU drops mov.
//
// Parameters
//   DEPTH        number of 32-bit words in the array (power of 2)
//   ADDR_W       width of the byte address input
//   WAIT_CYCLES  wait states between request capture and moc (0..15)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   mov    in   request valid (level, held until moc)
//   rw     in   1 = write, 0 = read
//   size   in   00 byte, 01 halfword, 10/11 word
//   addr   in   byte address (upper bits above the array wrap)
//   wdata  in   right-justified write data
//   moc    out  memory operation complete
//   rdata  out  right-justified, zero-extended read data (held between reads)
//   busy   out  high while waiting or acknowledging
//   err    out  misalignment flag; present only when ALIGN_CHECK_EN is defined
//
// Optional feature: define ALIGN_CHECK_EN to enable alignment checking.
// Misaligned halfword or word requests then skip the access and complete
// with err=1 alongside moc. Without the macro, the low address bits are
// truncated.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              moc,
  output logic [31:0]       rdata,
`ifdef ALIGN_CHECK_EN
  output logic              busy,
  output logic              err
`else
  output logic              busy
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              capture;
  logic              exec;

  // Captured request (only the address bits that reach the array are kept)
  logic              rw_reg;
  logic [1:0]        size_reg;
  logic [IDX_W+1:0]  addr_reg;
  logic [31:0]       wdata_reg;

  // Request seen by the access logic: live inputs when there are no wait
  // states (the access happens on the capture edge), captured copy otherwise.
  logic              x_rw;
  logic [1:0]        x_size;
  logic [IDX_W-1:0]  x_idx;
  logic [1:0]        x_lo;
  logic [31:0]       x_wdata;
  logic              x_mis;

  logic [3:0]        lane_en;
  logic [31:0]       lane_data;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_value;
  logic              do_write;
  logic [31:0]       rdata_reg;

  logic              unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:IDX_W+2];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // WAIT lasts exactly WAIT_CYCLES cycles. The counter is loaded with
  // WAIT_CYCLES and the access fires on the cycle it would decrement to zero.
  // This gives mov-to-moc latency of WAIT_CYCLES+1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    exec       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mov) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            exec       = 1'b1;
            state_next = ACK;
            cnt_next   = 4'd0;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          exec       = 1'b1;
          state_next = ACK;
          cnt_next   = 4'd0;
        end
      end
      ACK: begin
        if (!mov) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign moc  = (state_reg == ACK);
  assign busy = (state_reg == WAIT) || (state_reg == ACK);

  // ------------------------------------------------------ request capture
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_reg    <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
    end else if (capture) begin
      rw_reg    <= rw;
      size_reg  <= size;
      addr_reg  <= addr[IDX_W+1:0];
      wdata_reg <= wdata;
    end
  end

  generate
    if (WAIT_CYCLES == 0) begin : g_direct
      assign x_rw    = rw;
      assign x_size  = size;
      assign x_idx   = addr[IDX_W+1:2];
      assign x_lo    = addr[1:0];
      assign x_wdata = wdata;
    end else begin : g_captured
      assign x_rw    = rw_reg;
      assign x_size  = size_reg;
      assign x_idx   = addr_reg[IDX_W+1:2];
      assign x_lo    = addr_reg[1:0];
      assign x_wdata = wdata_reg;
    end
  endgenerate

  // ------------------------------------------------------ lane selection
  // lane_en[k] selects byte k, which lives at bits [31-8k -: 8] (big-endian).
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = x_wdata;
    case (x_size)
      2'b00: begin
        lane_en   = 4'b0001 << x_lo;
        lane_data = {4{x_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = x_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{x_wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = x_wdata;
      end
    endcase
  end

  // Byte k sits 8*(3-k) bits up from bit 0; ~x_lo == 3-x_lo for two bits.
  assign rd_shift = rd_word >> {~x_lo, 3'b000};

  always_comb begin
    rd_value = rd_word;
    case (x_size)
      2'b00:   rd_value = {24'd0, rd_shift[7:0]};
      2'b01:   rd_value = x_lo[1] ? {16'd0, rd_word[15:0]} : {16'd0, rd_word[31:16]};
      default: rd_value = rd_word;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  logic mis_reg;
  assign x_mis = ((x_size == 2'b01) && x_lo[0]) || (x_size[1] && (x_lo != 2'b00));

  always_ff @(posedge clk) begin
    if (reset)     mis_reg <= 1'b0;
    else if (exec) mis_reg <= x_mis;
  end

  assign err = moc && mis_reg;
`else
  assign x_mis = 1'b0;
`endif

  assign do_write = exec && x_rw && !x_mis;

  // --------------------------------------------------------- byte arrays
  // One byte-wide array per lane, so partial writes need no read-modify-write.
  // Reset only blocks the write (an aborted access must not land); contents
  // are never cleared.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (!reset && do_write && lane_en[gi]) begin
          mem[x_idx] <= lane_data[31-8*gi -: 8];
        end
      end

      assign rd_word[31-8*gi -: 8] = mem[x_idx];
    end
  endgenerate

  // rdata loads only when a (well-aligned) read completes and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= 32'd0;
    end else if (exec && !x_rw && !x_mis) begin
      rdata_reg <= rd_value;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mov;
  logic        rw;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        moc;
  logic [31:0] rdata;
  logic        busy;
  logic        err_obs;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          start;
    string       name;
  } exp_t;

  exp_t sb[$];

`ifdef ALIGN_CHECK_EN
  logic err;
  assign err_obs = err;
  mem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .addr(addr),
    .wdata(wdata), .moc(moc), .rdata(rdata), .busy(busy), .err(err)
  );
`else
  assign err_obs = 1'b0;
  mem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .mov(mov), .rw(rw), .size(size), .addr(addr),
    .wdata(wdata), .moc(moc), .rdata(rdata), .busy(busy)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising moc pops one expected response.
  initial begin
    exp_t e;
    logic moc_q;
    moc_q = 1'b0;
    forever begin
      @(negedge clk);
      if (moc === 1'b1 && moc_q !== 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_moc: got moc=1 at cycle %0d, expected no response", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_rdata"}, rdata, e.rdata);
          check({e.name, "_err"}, {31'd0, err_obs}, {31'd0, e.err});
          check({e.name, "_latency"}, 32'(cyc - e.start), 32'(WAIT_CYCLES + 1));
          $display("[TB] %s: rdata=%h err=%b latency=%0d", e.name, rdata, err_obs, cyc - e.start);
        end
      end
      moc_q = moc;
    end
  end

  // One handshake. Request fields are scrambled after capture to confirm they
  // are ignored outside IDLE. early_drop releases mov during the wait states.
  task automatic op(input string name, input logic w, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] exp_rd, input logic exp_err,
                    input int hold, input bit early_drop);
    exp_t e;
    bit   got;
    @(negedge clk);
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.start = cyc;
    e.name  = name;
    sb.push_back(e);
    rw = w; size = sz; addr = a; wdata = d; mov = 1'b1;
    @(negedge clk);
    rw = ~w; addr = ~a; wdata = ~d;
    if (early_drop) mov = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (moc === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no moc, expected moc within 20 cycles", name);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_moc_hold"}, {31'd0, moc}, 32'd1);
    end
    mov = 1'b0;
    @(negedge clk);
    check({name, "_moc_release"}, {31'd0, moc}, 32'd0);
    check({name, "_busy_release"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mov = 1'b0; rw = 1'b0; size = 2'b10; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_moc",   {31'd0, moc},     32'd0);
    check("reset_busy",  {31'd0, busy},    32'd0);
    check("reset_rdata", rdata,            32'd0);
    check("reset_err",   {31'd0, err_obs}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    op("w_word_10",   1'b1, 2'b10, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0, 0, 1'b0);
    op("r_word_10",   1'b0, 2'b10, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b0);
    op("w_word_20",   1'b1, 2'b10, 32'h20,  32'h11223344, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    op("w_byte_22",   1'b1, 2'b00, 32'h22,  32'h000000AA, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    op("r_word_20",   1'b0, 2'b10, 32'h20,  32'h0,        32'h1122AA44, 1'b0, 0, 1'b0);
    op("r_byte_23",   1'b0, 2'b00, 32'h23,  32'h0,        32'h00000044, 1'b0, 0, 1'b0);
    op("r_half_22",   1'b0, 2'b01, 32'h22,  32'h0,        32'h0000AA44, 1'b0, 0, 1'b0);
    op("r_half_20",   1'b0, 2'b01, 32'h20,  32'h0,        32'h00001122, 1'b0, 0, 1'b0);
    op("r_byte_21",   1'b0, 2'b00, 32'h21,  32'h0,        32'h00000022, 1'b0, 0, 1'b0);
    op("w_half_12",   1'b1, 2'b01, 32'h12,  32'h0000CAFE, 32'h00000022, 1'b0, 0, 1'b0);
    op("r_word_hold", 1'b0, 2'b10, 32'h10,  32'h0,        32'hDEADCAFE, 1'b0, 5, 1'b0);
    op("r_byte_drop", 1'b0, 2'b00, 32'h20,  32'h0,        32'h00000011, 1'b0, 0, 1'b1);
    op("w_wrap_400",  1'b1, 2'b10, 32'h400, 32'h00000005, 32'h00000011, 1'b0, 0, 1'b0);
    op("r_wrap_0",    1'b0, 2'b10, 32'h0,   32'h0,        32'h00000005, 1'b0, 0, 1'b0);
    op("w_word_30",   1'b1, 2'b10, 32'h30,  32'h12345678, 32'h00000005, 1'b0, 0, 1'b0);

    // Write aborted by reset while waiting: no moc, no array update.
    @(negedge clk);
    rw = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'h00000077; mov = 1'b1;
    @(negedge clk);
    reset = 1'b1; mov = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_moc",   {31'd0, moc},  32'd0);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_rdata", rdata,         32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_moc_quiet", {31'd0, moc}, 32'd0);
    end
    $display("[TB] abort_w_30: reset during wait, moc stayed low");

    op("r_word_30",   1'b0, 2'b10, 32'h30,  32'h0,        32'h12345678, 1'b0, 0, 1'b0);
`ifdef ALIGN_CHECK_EN
    op("r_misalign",  1'b0, 2'b10, 32'h22,  32'h0,        32'h12345678, 1'b1, 2, 1'b0);
`else
    op("r_misalign",  1'b0, 2'b10, 32'h22,  32'h0,        32'h1122AA44, 1'b0, 2, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
